shop_arb_v: RTL

SHOP_ARB_V -- requirements
Module: shop_arb_v

---
 rtl/shop_arb_v_if.sv | 33 +++
 rtl/shop_arb_v.sv | 117 +++++++++++
 2 files changed

// File: rtl/shop_arb_v_if.sv
// Request/response bundle for the two-requester boolean-function arbiter.
// slave is the arbiter side; master is the requester/consumer side.
interface shop_arb_v_if;
  logic       i_req0_valid;
  logic [2:0] i_req0_abc;
  logic [1:0] i_req0_code;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [2:0] i_req1_abc;
  logic [1:0] i_req1_code;
  logic       o_req1_ready;
  logic       o_rsp_valid;
  logic       o_rsp_id;
  logic       o_rsp_f;
  logic       i_rsp_ready;
  logic       o_busy;

  modport slave (
    input  i_req0_valid, i_req0_abc, i_req0_code,
    input  i_req1_valid, i_req1_abc, i_req1_code,
    input  i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_f, o_busy
  );

  modport master (
    output i_req0_valid, i_req0_abc, i_req0_code,
    output i_req1_valid, i_req1_abc, i_req1_code,
    output i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_f, o_busy
  );
endinterface

// File: rtl/shop_arb_v.sv
// Round-robin arbiter for two requesters evaluating a 3-input boolean function; response EVAL_LAT+1 cycles after transfer.
// One job in flight: no request is accepted until the held response is taken by i_rsp_ready.
module shop_arb_v #(
  parameter int unsigned EVAL_LAT = 2
) (
  input logic         i_clk,
  input logic         i_rst_n,
  shop_arb_v_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EVAL_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_served;
  logic [3:0] cnt;
  logic [2:0] abc_q;
  logic [1:0] code_q;
  logic       id_q;
  logic       rsp_id_q;
  logic       rsp_f_q;
  logic       grant0;
  logic       grant1;
  logic       xfer;
  logic       eval_done;
  logic       rsp_hs;
  logic       f_nxt;

  // Ready is gated by reset so nothing can be granted before the first edge after release.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_rst_n && state == IDLE) begin
      if (bus.i_req0_valid && (!bus.i_req1_valid || last_served)) begin
        grant0 = 1'b1;
      end else if (bus.i_req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign xfer      = grant0 | grant1;
  assign eval_done = (state == EVAL) && (cnt == 4'd0);
  assign rsp_hs    = (state == RESP) && bus.i_rsp_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = EVAL;
      EVAL:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (bus.i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    f_nxt = 1'b0;
    case (code_q)
      2'b00: f_nxt = ^abc_q;
      2'b01: f_nxt = ~&abc_q;
      2'b10: f_nxt = ~|abc_q;
      2'b11: f_nxt = ~^abc_q;
      default: f_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_served <= 1'b1;
      cnt         <= 4'd0;
      abc_q       <= 3'd0;
      code_q      <= 2'd0;
      id_q        <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_f_q     <= 1'b0;
    end else begin
      if (xfer) begin
        abc_q  <= grant0 ? bus.i_req0_abc  : bus.i_req1_abc;
        code_q <= grant0 ? bus.i_req0_code : bus.i_req1_code;
        id_q   <= grant1;
        cnt    <= CNT_LOAD;
      end else if (state == EVAL && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Result and owner are captured only on the EVAL->RESP transition.
      if (eval_done) begin
        rsp_id_q <= id_q;
        rsp_f_q  <= f_nxt;
      end
      if (rsp_hs) begin
        last_served <= rsp_id_q;
      end
    end
  end

  assign bus.o_req0_ready = grant0;
  assign bus.o_req1_ready = grant1;
  assign bus.o_rsp_valid  = (state == RESP);
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_rsp_f      = rsp_f_q;
  assign bus.o_busy       = (state != IDLE);

endmodule
